// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: forwarding select encoding,
// the shadow pipeline tag layout and the forwarding priority helper.
package hazard_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [REG_IDX_W-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [REG_IDX_W-1:0] ra1;
        logic [REG_IDX_W-1:0] ra2;
        logic [REG_IDX_W-1:0] wa3;
        logic                 regwrite;
        logic                 memtoreg;
        logic                 pcsrc;
    } stage_tag_t;

    // Memory stage beats Writeback; the PC is read from the fetch path, never forwarded.
    function automatic fwd_sel_t fwd_sel(
        input logic [REG_IDX_W-1:0] ra,
        input logic                 regwrite_m,
        input logic [REG_IDX_W-1:0] wa3_m,
        input logic                 regwrite_w,
        input logic [REG_IDX_W-1:0] wa3_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra != PC_REG) begin
            if (regwrite_m && (wa3_m == ra))
                sel = FWD_MEM;
            else if (regwrite_w && (wa3_w == ra))
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard debug event counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding unit: tracks register tags through a shadow E/M/W
// pipeline and drives stall, flush and Execute operand forwarding selects.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             CondExE,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] LdStallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    if (REG_W != REG_IDX_W) begin : g_reg_w_check
        $error("hazard_unit: REG_W must match hazard_pkg::REG_IDX_W");
    end

    stage_tag_t           e_q, e_d;
    logic                 m_regwrite_q, m_pcsrc_q;
    logic [REG_W-1:0]     m_wa3_q;
    logic                 w_regwrite_q, w_pcsrc_q;
    logic [REG_W-1:0]     w_wa3_q;

    logic ldrstall;
    logic pcpend;
    logic branch_taken;
    logic flush_e;

    // Everything combinational is qualified by reset so outputs read 0 while it is low.
    assign ldrstall     = reset & e_q.memtoreg & e_q.regwrite &
                          ((RA1D == e_q.wa3) | (RA2D == e_q.wa3));
    assign pcpend       = reset & (PCSrcD | e_q.pcsrc | m_pcsrc_q);
    assign branch_taken = reset & BranchTakenE;
    assign flush_e      = ldrstall | branch_taken;

    always_comb begin
        e_d = '{ra1: RA1D, ra2: RA2D, wa3: WA3D,
                regwrite: RegWriteD, memtoreg: MemtoRegD, pcsrc: PCSrcD};
        if (flush_e) begin
            e_d.regwrite = 1'b0;
            e_d.memtoreg = 1'b0;
            e_d.pcsrc    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q          <= '0;
            m_regwrite_q <= 1'b0;
            m_pcsrc_q    <= 1'b0;
            m_wa3_q      <= '0;
            w_regwrite_q <= 1'b0;
            w_pcsrc_q    <= 1'b0;
            w_wa3_q      <= '0;
        end else begin
            e_q          <= e_d;
            m_regwrite_q <= e_q.regwrite & CondExE;
            m_pcsrc_q    <= e_q.pcsrc & CondExE;
            m_wa3_q      <= e_q.wa3;
            w_regwrite_q <= m_regwrite_q;
            w_pcsrc_q    <= m_pcsrc_q;
            w_wa3_q      <= m_wa3_q;
        end
    end

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reset) begin
            ForwardAE = fwd_sel(e_q.ra1, m_regwrite_q, m_wa3_q, w_regwrite_q, w_wa3_q);
            ForwardBE = fwd_sel(e_q.ra2, m_regwrite_q, m_wa3_q, w_regwrite_q, w_wa3_q);
        end
    end

    assign StallF = ldrstall | pcpend;
    assign StallD = ldrstall;
    assign FlushD = pcpend | (reset & w_pcsrc_q) | branch_taken;
    assign FlushE = flush_e;

    sat_counter #(.W(CNT_W)) u_ldstall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ldrstall),
        .count (LdStallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_taken),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use stall, PC flush,
// branch/stall overlap, counter saturation and asynchronous reset.
module tb_hazard_unit;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] RA1D, RA2D, WA3D;
    logic             RegWriteD, MemtoRegD, PCSrcD;
    logic             CondExE, BranchTakenE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] LdStallCnt, FlushCnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .WA3D         (WA3D),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .LdStallCnt   (LdStallCnt),
        .FlushCnt     (FlushCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setd(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                        input logic rw, input logic mr, input logic pc);
        RA1D = ra1; RA2D = ra2; WA3D = wa3;
        RegWriteD = rw; MemtoRegD = mr; PCSrcD = pc;
        #1;
    endtask

    task automatic nop();
        setd(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {StallF, StallD, FlushD, FlushE}
    task automatic chk_sf(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, StallF, StallD, FlushD, FlushE}, {28'd0, exp});
    endtask

    initial begin
        reset = 1'b0;
        CondExE = 1'b1;
        BranchTakenE = 1'b1;
        setd(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1);
        chk_sf("reset_stall_flush", 4'b0000);
        chk("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        chk("reset_cnt", {24'd0, LdStallCnt, FlushCnt}, 32'd0);
        BranchTakenE = 1'b0;
        nop();
        @(negedge clk);
        reset = 1'b1;
        tick(); tick(); tick();

        // ADD R1 -> SUB R2,R1,R3 -> ORR R7,R1,R0
        setd(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0);
        chk_sf("add_no_hazard", 4'b0000);
        tick();
        setd(4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0);
        chk_sf("sub_no_stall", 4'b0000);
        tick();
        setd(4'd1, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
        chk("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
        chk("fwdB_rf", {30'd0, ForwardBE}, 32'd0);
        tick();
        nop();
        chk("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
        chk("fwdB_rf2", {30'd0, ForwardBE}, 32'd0);
        tick(); tick(); tick();

        // Two writers of R8 in flight: Memory wins, then Writeback
        setd(4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0); tick();
        setd(4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0); tick();
        setd(4'd8, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0); tick();
        setd(4'd8, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("fwd_mem_priority", {30'd0, ForwardAE}, 32'd2);
        tick();
        nop();
        chk("fwd_wb_after", {28'd0, ForwardAE, ForwardBE}, 32'b0101);
        tick(); tick(); tick();

        // R15 write in flight is never forwarded
        setd(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0); tick();
        setd(4'd15, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0); tick();
        nop();
        chk("fwd_r15", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        tick(); tick(); tick();

        // LDR R4 ; ADD R5,R4,R4
        setd(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
        chk_sf("ldr_issue", 4'b0000);
        tick();
        setd(4'd4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        chk_sf("ldr_use_stall", 4'b1101);
        chk("ldcnt_pre", {28'd0, LdStallCnt}, 32'd0);
        tick();
        chk_sf("ldr_stall_over", 4'b0000);
        chk("ldcnt_1", {28'd0, LdStallCnt}, 32'd1);
        tick();
        nop();
        chk("ldr_fwd_wb", {28'd0, ForwardAE, ForwardBE}, 32'b0101);
        tick(); tick(); tick();

        // Conditional ADD R6 fails its condition
        setd(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0); tick();
        CondExE = 1'b0;
        setd(4'd6, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0); tick();
        CondExE = 1'b1;
        nop();
        chk("cond_fail_m", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        tick();
        chk("cond_fail_w", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        tick(); tick(); tick();

        // PC write: StallF for D,E,M; FlushD for D,E,M,W
        setd(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_sf("pc_d", 4'b1010);
        tick(); nop();
        chk_sf("pc_e", 4'b1010);
        tick();
        chk_sf("pc_m", 4'b1010);
        tick();
        chk_sf("pc_w", 4'b0010);
        tick();
        chk_sf("pc_done", 4'b0000);
        tick(); tick();

        // Branch taken together with load-use stall
        setd(4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0); tick();
        setd(4'd9, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        BranchTakenE = 1'b1;
        #1;
        chk_sf("br_ld_both", 4'b1111);
        chk("flushcnt_pre", {28'd0, FlushCnt}, 32'd0);
        tick();
        BranchTakenE = 1'b0;
        #1;
        chk_sf("br_ld_bubble", 4'b0000);
        chk("flushcnt_1", {28'd0, FlushCnt}, 32'd1);
        chk("ldcnt_2", {28'd0, LdStallCnt}, 32'd2);

        // Self-dependent load stalls on every other cycle; 42 cycles saturate the count
        for (int i = 0; i < 42; i++) begin
            setd(4'd4, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
            tick();
        end
        chk("ldcnt_sat", {28'd0, LdStallCnt}, 32'd15);
        chk("flushcnt_hold", {28'd0, FlushCnt}, 32'd1);

        // Reset asserted mid-stall
        setd(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        setd(4'd4, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        BranchTakenE = 1'b1;
        #1;
        chk_sf("pre_reset_stall", 4'b1111);
        reset = 1'b0;
        #1;
        chk_sf("async_reset_sf", 4'b0000);
        chk("async_reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
        chk("async_reset_cnt", {24'd0, LdStallCnt, FlushCnt}, 32'd0);
        #2;
        BranchTakenE = 1'b0;
        reset = 1'b1;
        #1;
        chk_sf("post_reset_empty", 4'b0000);
        tick();
        chk("post_reset_cnt", {24'd0, LdStallCnt, FlushCnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard and forwarding unit for the 5-stage pipelined ARM core. It is the consumer counterpart of the pipelined controller.
- The controller issues per-stage control into the pipeline registers. This block watches the instructions in flight and drives the other side of those registers: stall and flush enables, plus operand forwarding selects for the Execute stage.
- It keeps its own shadow pipeline of register tags (E/M/W) and saturating hazard counters for debug.

Parameters:
- REG_W, 4, width of a register index.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- RA1D  in  REG_W  first source register of the Decode instruction
- RA2D  in  REG_W  second source register of the Decode instruction
- WA3D  in  REG_W  destination register of the Decode instruction
- RegWriteD  in  1  Decode instruction writes the register file
- MemtoRegD  in  1  Decode instruction is a load
- PCSrcD  in  1  Decode instruction writes the PC
- CondExE  in  1  condition check passed for the Execute instruction
- BranchTakenE  in  1  branch resolved taken in Execute
- ForwardAE  out  2  SrcA select: 00 register file, 01 Writeback result, 10 Memory ALU result
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE
- StallF  out  1  hold PC
- StallD  out  1  hold the F/D register
- FlushD  out  1  clear the F/D register
- FlushE  out  1  clear the D/E register
- LdStallCnt  out  CNT_W  count of load-use stall cycles
- FlushCnt  out  CNT_W  count of cycles with FlushE caused by a taken branch

Behaviour:
- Reset (reset=0, asynchronous):
  - All shadow tags and valid bits clear, both counters 0.
  - All outputs are forced to 0 while reset is low, including the combinational ones.
- Shadow E register, updated on the clk rising edge:
  - If FlushE: RegWriteE, MemtoRegE and PCSrcE clear.
  - Else: E takes {RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD}.
- Shadow M register:
  - RegWriteM <= RegWriteE & CondExE.
  - PCSrcM <= PCSrcE & CondExE.
  - WA3M <= WA3E.
- Shadow W register copies M.
- Latency: one cycle per stage. A Decode instruction's tag reaches W after three edges.
- Forwarding (combinational from the shadow registers):
  - ForwardAE = 10 if RegWriteM and WA3M==RA1E.
  - Else 01 if RegWriteW and WA3W==RA1E.
  - Else 00.
  - Memory wins over Writeback when both match.
  - R15 (index 15) is never forwarded: select is 00.
  - ForwardBE is identical, using RA2E.
- Load-use stall: ldrstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
- PC pending: pcpend = PCSrcD | PCSrcE | PCSrcM.
- Stall and flush outputs:
  - StallF = ldrstall | pcpend.
  - StallD = ldrstall.
  - FlushD = pcpend | PCSrcW | BranchTakenE.
  - FlushE = ldrstall | BranchTakenE.
- Simultaneous ldrstall and BranchTakenE: all four of StallD, FlushD, StallF and FlushE assert. The datapath gives flush priority over stall. The E shadow loads a bubble.
- Counters:
  - LdStallCnt increments on every cycle with ldrstall=1.
  - FlushCnt increments on every cycle with BranchTakenE=1.
  - Both saturate at 2^CNT_W-1; no wrap.
- Reset asserted mid-stall clears the pending bubble; the first cycle after release behaves as an empty pipeline.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
  - constant PC_REG=4'd15
  - struct stage_tag_t {ra1, ra2, wa3, regwrite, memtoreg, pcsrc}
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- ADD R1 in D, then SUB R2,R1,R3 in the next cycle -> two edges later, with SUB in E, ForwardAE=10. One cycle further, an instruction reading R1 sees ForwardAE=01.
- LDR R4, then ADD R5,R4,R4 immediately after -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=ForwardBE=01; LdStallCnt=1.
- Conditional ADD R6 with CondExE=0 in E, consumer reading R6 follows -> ForwardAE stays 00 (RegWriteM cleared).
- PCSrcD=1 for one cycle -> StallF high for 3 cycles (pcpend across D, E, M), FlushD high for 4 cycles (including the W cycle).
- BranchTakenE=1 coincident with ldrstall -> FlushD=FlushE=StallD=StallF=1, E shadow bubbled, FlushCnt=1, LdStallCnt=1.
- Drive ldrstall continuously for 2^CNT_W+5 cycles with CNT_W=4 -> LdStallCnt holds at 15. Then reset low mid-operation -> all outputs 0 immediately (asynchronous), counters 0.
